// File: rtl/game_state_frame_rx_if.sv
// rtl/game_state_frame_rx_if.sv - byte stream from the UART receiver into the game-state frame receiver
//
// Signals:
//   rx_data   8-bit byte from the UART receiver
//   rx_valid  one-cycle strobe, rx_data valid
// Modports:
//   master    byte source (UART RX side)
//   slave     byte sink (frame receiver)
interface game_state_frame_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/game_state_frame_rx.sv
// rtl/game_state_frame_rx.sv - rebuilds game-state buses from a checksummed byte-stream frame
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx                  byte stream in (rx_data / rx_valid), slave modport
//   current_state ..    decoded game-state fields, updated only on a good frame
//   time_in_seconds
//   frame_valid         one-cycle pulse, decoded outputs updated this cycle
//   frame_error         one-cycle pulse, frame discarded (bad checksum or timeout)
//   busy                high while a frame is being received
module game_state_frame_rx #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         PAYLOAD_BYTES  = 66,
  parameter int         TIMEOUT_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  game_state_frame_rx_if.slave  rx,
  output logic [2:0]            current_state,
  output logic                  game_dificulty,
  output logic [323:0]          full_board,
  output logic [161:0]          colors,
  output logic [7:0]            position,
  output logic [1:0]            errors,
  output logic [3:0]            selected_number,
  output logic                  victory_condition,
  output logic [6:0]            score,
  output logic [10:0]           time_in_seconds,
  output logic                  frame_valid,
  output logic                  frame_error,
  output logic                  busy
);

  // Only the 523 meaningful payload bits are kept; the 5 pad bits at the
  // top of the first byte simply shift out of the register.
  localparam int FIELD_W = 523;
  localparam int CNT_W   = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PAYLOAD_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_CHECK
  } state_t;

  state_t               state_q;
  logic [FIELD_W-1:0]   shift_q;
  logic [FIELD_W-1:0]   shift_d;
  logic [FIELD_W-1:0]   fields_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [7:0]           xor_q;
  logic [7:0]           xor_d;
  logic [TMO_W-1:0]     tmo_q;
  logic                 frame_valid_q;
  logic                 frame_error_q;

  assign shift_d = {shift_q[FIELD_W-9:0], rx.rx_data};
  assign xor_d   = xor_q ^ rx.rx_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      fields_q      <= '0;
      cnt_q         <= '0;
      xor_q         <= '0;
      tmo_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx.rx_valid && rx.rx_data == SYNC_BYTE) begin
            state_q <= S_PAYLOAD;
            cnt_q   <= '0;
            xor_q   <= '0;
            tmo_q   <= '0;
          end
        end
        S_PAYLOAD: begin
          // Sync-valued bytes here are plain data: no resync inside a frame.
          if (rx.rx_valid) begin
            shift_q <= shift_d;
            xor_q   <= xor_d;
            cnt_q   <= cnt_q + 1'b1;
            tmo_q   <= '0;
            if (cnt_q == LAST_BYTE) state_q <= S_CHECK;
          end else if (tmo_q == TMO_LAST) begin
            frame_error_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (rx.rx_valid) begin
            // Whole word is committed in one edge so consumers never see a
            // mix of old and new fields.
            if (rx.rx_data == xor_q) begin
              fields_q      <= shift_q;
              frame_valid_q <= 1'b1;
            end else begin
              frame_error_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end else if (tmo_q == TMO_LAST) begin
            frame_error_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign time_in_seconds   = fields_q[10:0];
  assign score             = fields_q[17:11];
  assign victory_condition = fields_q[18];
  assign selected_number   = fields_q[22:19];
  assign errors            = fields_q[24:23];
  assign position          = fields_q[32:25];
  assign colors            = fields_q[194:33];
  assign full_board        = fields_q[518:195];
  assign game_dificulty    = fields_q[519];
  assign current_state     = fields_q[522:520];

  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_game_state_frame_rx.sv
// tb/tb_game_state_frame_rx.sv - self-checking bench for game_state_frame_rx
module tb_game_state_frame_rx;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         NPL  = 66;
  localparam int         TMO  = 16;
  localparam int         NVEC = 5;

  logic clk;
  logic rst_n;

  logic [2:0]   current_state;
  logic         game_dificulty;
  logic [323:0] full_board;
  logic [161:0] colors;
  logic [7:0]   position;
  logic [1:0]   errors;
  logic [3:0]   selected_number;
  logic         victory_condition;
  logic [6:0]   score;
  logic [10:0]  time_in_seconds;
  logic         frame_valid;
  logic         frame_error;
  logic         busy;

  game_state_frame_rx_if rx_if ();

  game_state_frame_rx #(
    .SYNC_BYTE      (SYNC),
    .PAYLOAD_BYTES  (NPL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rx                (rx_if.slave),
    .current_state     (current_state),
    .game_dificulty    (game_dificulty),
    .full_board        (full_board),
    .colors            (colors),
    .position          (position),
    .errors            (errors),
    .selected_number   (selected_number),
    .victory_condition (victory_condition),
    .score             (score),
    .time_in_seconds   (time_in_seconds),
    .frame_valid       (frame_valid),
    .frame_error       (frame_error),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]   st;
    logic         dif;
    logic [323:0] board;
    logic [161:0] col;
    logic [7:0]   pos;
    logic [1:0]   err;
    logic [3:0]   sel;
    logic         vic;
    logic [6:0]   sc;
    logic [10:0]  tm;
    bit           bad;
    bit           junk;
    bit           exp_good;
  } vec_t;

  typedef struct {
    bit           is_err;
    logic [522:0] word;
    int           due;
  } ev_t;

  vec_t         vec [NVEC];
  ev_t          sbq [$];
  logic [522:0] model;
  int           n_checks = 0;
  int           n_fail   = 0;

  function automatic logic [522:0] vword(input vec_t v);
    return {v.st, v.dif, v.board, v.col, v.pos, v.err, v.sel, v.vic, v.sc, v.tm};
  endfunction

  function automatic logic [323:0] gen_board(input int seed);
    logic [323:0] b;
    for (int c = 0; c < 81; c++) b[323-4*c -: 4] = 4'((c * 7 + seed) % 10);
    return b;
  endfunction

  function automatic logic [522:0] dut_word();
    return {current_state, game_dificulty, full_board, colors, position, errors,
            selected_number, victory_condition, score, time_in_seconds};
  endfunction

  task automatic chk(input string name, input logic [522:0] act, input logic [522:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_if.rx_valid = 1'b0;
    end
  endtask

  task automatic gap(input bit cont);
    if (!cont) idle(1);
  endtask

  // Sends one full frame; the expected pulse is queued for the monitor.
  task automatic send_frame(input logic [522:0] w, input bit bad, input bit junk, input bit cont);
    logic [527:0] pl;
    logic [7:0]   x;
    logic [7:0]   b;
    pl = {5'b0, w};
    x  = 8'h00;
    if (junk) begin
      send_byte(8'h00); gap(cont);
      send_byte(8'h3C); gap(cont);
    end
    send_byte(SYNC); gap(cont);
    for (int k = 0; k < NPL; k++) begin
      b = pl[527-8*k -: 8];
      x = x ^ b;
      send_byte(b); gap(cont);
    end
    if (bad) x = x ^ 8'h01;
    send_byte(x);
    sbq.push_back('{is_err: bad, word: w, due: cyc + 1});
    if (!bad) model = w;
    gap(cont);
  endtask

  // Monitor: every pulse must match the head of the scoreboard, in kind, cycle and content.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      if (frame_valid && frame_error) begin
        n_checks++;
        n_fail++;
        $display("FAIL pulse_exclusive: frame_valid=1 frame_error=1 required not both");
      end
      if (frame_valid || frame_error) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: valid=%0b error=%0b at cycle %0d, none required", frame_valid, frame_error, cyc);
        end else begin
          e = sbq.pop_front();
          chk("pulse_kind_error", 523'(frame_error), 523'(e.is_err));
          chk("pulse_cycle", 523'(cyc), 523'(e.due));
          if (frame_valid) chk("frame_fields", dut_word(), e.word);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [522:0] w;
    logic [527:0] pl;
    vec_t v;

    // Table: good frame, bad checksum, junk + embedded sync, max fields, all-zero frame.
    v = '{st: 3'b010, dif: 1'b0, board: gen_board(3), col: {81{2'b01}}, pos: 8'h58,
          err: 2'd2, sel: 4'd3, vic: 1'b0, sc: 7'h00, tm: 11'd0, bad: 0, junk: 0, exp_good: 1};
    v.board[323:308] = 16'h0196;
    v.board[11:0]    = 12'h170;
    vec[0] = v;
    vec[1] = v;
    vec[1].bad = 1; vec[1].exp_good = 0; vec[1].st = 3'b101; vec[1].pos = 8'h11;
    vec[2] = '{st: 3'b001, dif: 1'b1, board: gen_board(5), col: {81{2'b10}}, pos: 8'h34,
               err: 2'd1, sel: 4'd9, vic: 1'b0, sc: 7'h2A, tm: 11'h0A5, bad: 0, junk: 1, exp_good: 1};
    vec[3] = '{st: 3'b111, dif: 1'b1, board: {324{1'b1}}, col: {162{1'b1}}, pos: 8'hFF,
               err: 2'd3, sel: 4'hF, vic: 1'b1, sc: 7'h7F, tm: 11'h7FF, bad: 0, junk: 0, exp_good: 1};
    vec[4] = '{st: 3'b000, dif: 1'b0, board: '0, col: '0, pos: 8'h00,
               err: 2'd0, sel: 4'd0, vic: 1'b0, sc: 7'h00, tm: 11'd0, bad: 0, junk: 0, exp_good: 1};

    model          = '0;
    rst_n          = 1'b0;
    rx_if.rx_data  = 8'h00;
    rx_if.rx_valid = 1'b0;
    idle(3);
    chk("reset_outputs", dut_word(), '0);
    chk("reset_busy", 523'(busy), 523'(0));
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < NVEC; i++) begin
      send_frame(vword(vec[i]), vec[i].bad, vec[i].junk, 1'b0);
      idle(3);
      chk($sformatf("vec%0d_outputs", i), dut_word(), vec[i].exp_good ? vword(vec[i]) : model);
      chk($sformatf("vec%0d_busy", i), 523'(busy), 523'(0));
    end

    // Timeout: stall after payload byte 10.
    w  = vword(vec[2]);
    pl = {5'b0, w};
    send_byte(SYNC); idle(1);
    for (int k = 0; k <= 10; k++) begin
      send_byte(pl[527-8*k -: 8]);
      if (k < 10) idle(1);
    end
    chk("timeout_busy_mid", 523'(busy), 523'(1));
    sbq.push_back('{is_err: 1'b1, word: '0, due: cyc + 1 + TMO});
    idle(TMO + 4);
    chk("timeout_busy_after", 523'(busy), 523'(0));
    chk("timeout_outputs_held", dut_word(), model);
    send_frame(vword(vec[0]), 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("after_timeout_frame", dut_word(), vword(vec[0]));

    // Mid-frame reset after payload byte 30.
    pl = {5'b0, vword(vec[3])};
    send_byte(SYNC); idle(1);
    for (int k = 0; k <= 30; k++) begin
      send_byte(pl[527-8*k -: 8]);
      idle(1);
    end
    rst_n = 1'b0;
    #1;
    model = '0;
    chk("midreset_outputs", dut_word(), '0);
    chk("midreset_busy", 523'(busy), 523'(0));
    idle(3);
    rst_n = 1'b1;
    idle(2);
    send_frame(vword(vec[2]), 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("after_reset_frame", dut_word(), vword(vec[2]));

    // Back-to-back frames with rx_valid held high throughout.
    v = vec[0];
    v.st = 3'b011;
    send_frame(vword(v), 1'b0, 1'b0, 1'b1);
    send_frame(vword(vec[0]), 1'b0, 1'b0, 1'b1);
    idle(4);
    chk("b2b_state", 523'(current_state), 523'(3'b010));
    chk("b2b_outputs", dut_word(), vword(vec[0]));

    chk("scoreboard_drained", 523'(sbq.size()), 523'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
